alu_iter: RTL and testbench

- Parametrised, handshaked successor to the core's combinational ALU.
- Executes RV32I/RV64I integer ops in one cycle. Executes RV M-extension multiply, divide and remainder iteratively, one bit per cycle.
- Sits between decode/operand-fetch and writeback. The pipeline stalls on `ready_o` low and retires on `valid_o && ready_i`.

---
 rtl/alu_iter.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_iter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// Handshaked integer ALU: RV32I/RV64I ops complete in one cycle.
// M-extension multiply/divide/remainder iterate one bit per cycle.
module alu_iter #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] ALUResult_o,
  output logic            zero_o,
  output logic            illegal_o
);

  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d, illegal_q, illegal_d;
  logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic              bSigned_q, bSigned_d, hiSel_q, hiSel_d;
  logic              isRem_q, isRem_d, negQ_q, negQ_d, negR_q, negR_d;

  logic              isMul, isDiv, isSingle, divSigned, aNeg, bNeg, divZero, divOvf;
  logic [XLEN-1:0]   absA, absB, immRes;
  logic [SHW-1:0]    shamt;
  logic              lastIter;
  logic [2*XLEN-1:0] addend, mulSum;
  logic [XLEN-1:0]   mulRes;
  logic [XLEN:0]     remShift, remDiff;
  logic              geq;
  logic [XLEN-1:0]   remNext, quoNext, divRes;

  assign isMul     = op_i[4:2] == 3'b100;
  assign isDiv     = op_i[4:2] == 3'b101;
  assign isSingle  = op_i <= 5'd9;
  assign divSigned = isDiv && !op_i[0];
  assign aNeg      = divSigned && operand1_i[XLEN-1];
  assign bNeg      = divSigned && operand2_i[XLEN-1];
  assign divZero   = operand2_i == '0;
  assign divOvf    = divSigned && (operand1_i == {1'b1, {(XLEN-1){1'b0}}}) && (operand2_i == '1);
  assign absA      = aNeg ? -operand1_i : operand1_i;
  assign absB      = bNeg ? -operand2_i : operand2_i;
  assign shamt     = operand2_i[SHW-1:0];

  // Results that finish at the accept edge, including the divide corner cases.
  always_comb begin
    immRes = '0;
    case (op_i)
      5'd0:       immRes = operand1_i & operand2_i;
      5'd1:       immRes = operand1_i | operand2_i;
      5'd2:       immRes = operand1_i + operand2_i;
      5'd3:       immRes = operand1_i - operand2_i;
      5'd4:       immRes = operand1_i ^ operand2_i;
      5'd5:       immRes = operand1_i << shamt;
      5'd6:       immRes = operand1_i >> shamt;
      5'd7:       immRes = {{(XLEN-1){1'b0}}, operand1_i < operand2_i};
      5'd8:       immRes = $signed(operand1_i) >>> shamt;
      5'd9:       immRes = {{(XLEN-1){1'b0}}, $signed(operand1_i) < $signed(operand2_i)};
      5'd20, 5'd21: immRes = divZero ? '1 : operand1_i;
      5'd22, 5'd23: immRes = divZero ? operand1_i : '0;
      default:    immRes = '0;
    endcase
  end

  assign lastIter = cnt_q == SHW'(XLEN-1);

  // The multiplier MSB carries negative weight for signed B, so the last step subtracts.
  assign addend = mplier_q[0] ? mcand_q : '0;
  assign mulSum = (lastIter && bSigned_q) ? acc_q - addend : acc_q + addend;
  assign mulRes = hiSel_q ? mulSum[2*XLEN-1:XLEN] : mulSum[XLEN-1:0];

  assign remShift = {rem_q, quo_q[XLEN-1]};
  assign remDiff  = remShift - {1'b0, dvsr_q};
  assign geq      = !remDiff[XLEN];
  assign remNext  = geq ? remDiff[XLEN-1:0] : remShift[XLEN-1:0];
  assign quoNext  = {quo_q[XLEN-2:0], geq};
  assign divRes   = isRem_q ? (negR_q ? -remNext : remNext) : (negQ_q ? -quoNext : quoNext);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    bSigned_d = bSigned_q;
    hiSel_d   = hiSel_q;
    isRem_d   = isRem_q;
    negQ_d    = negQ_q;
    negR_d    = negR_q;
    case (state_q)
      IDLE: begin
        if (valid_i && !kill_i) begin
          cnt_d = '0;
          if (isMul) begin
            state_d   = MUL;
            acc_d     = '0;
            mcand_d   = (op_i == OP_MULH || op_i == OP_MULHSU) ?
                        {{XLEN{operand1_i[XLEN-1]}}, operand1_i} : {{XLEN{1'b0}}, operand1_i};
            mplier_d  = operand2_i;
            bSigned_d = op_i == OP_MULH;
            hiSel_d   = op_i != OP_MUL;
          end else if (isDiv && !divZero && !divOvf) begin
            state_d = DIV;
            rem_d   = '0;
            quo_d   = absA;
            dvsr_d  = absB;
            isRem_d = op_i[1];
            negQ_d  = aNeg ^ bNeg;
            negR_d  = aNeg;
          end else begin
            state_d   = DONE;
            result_d  = immRes;
            zero_d    = immRes == '0;
            illegal_d = !(isSingle || isMul || isDiv);
          end
        end
      end
      MUL: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          acc_d    = mulSum;
          mcand_d  = {mcand_q[2*XLEN-2:0], 1'b0};
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + SHW'(1);
          if (lastIter) begin
            state_d   = DONE;
            result_d  = mulRes;
            zero_d    = mulRes == '0;
            illegal_d = 1'b0;
          end
        end
      end
      DIV: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          rem_d = remNext;
          quo_d = quoNext;
          cnt_d = cnt_q + SHW'(1);
          if (lastIter) begin
            state_d   = DONE;
            result_d  = divRes;
            zero_d    = divRes == '0;
            illegal_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (kill_i || ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      bSigned_q <= 1'b0;
      hiSel_q   <= 1'b0;
      isRem_q   <= 1'b0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      bSigned_q <= bSigned_d;
      hiSel_q   <= hiSel_d;
      isRem_q   <= isRem_d;
      negQ_q    <= negQ_d;
      negR_q    <= negR_d;
    end
  end

  assign ready_o     = state_q == IDLE;
  assign valid_o     = state_q == DONE;
  assign ALUResult_o = result_q;
  assign zero_o      = zero_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: one 32-bit and one 64-bit instance share the
// stimulus bus; expected results come from a behavioural reference model.
module tb_alu_iter;

  localparam logic [4:0] AND_ = 5'd0,  ADD = 5'd2,  SUB = 5'd3,  SRA = 5'd8;
  localparam logic [4:0] SLT  = 5'd9,  SLTU = 5'd7, MUL = 5'd16, MULH = 5'd17;
  localparam logic [4:0] MULHSU = 5'd18, MULHU = 5'd19, DIV = 5'd20, DIVU = 5'd21;
  localparam logic [4:0] REM  = 5'd22, REMU = 5'd23;

  typedef struct {
    logic [63:0] res;
    logic        zero;
    logic        ill;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN, valid32, valid64, kill, readyIn;
  logic [4:0]  op;
  logic [31:0] a32, b32;
  logic [63:0] a64, b64;
  logic        ready32, vOut32, zero32, ill32;
  logic        ready64, vOut64, zero64, ill64;
  logic [31:0] res32;
  logic [63:0] res64;

  int   checks = 0;
  int   errors = 0;
  exp_t sbQ[$];

  always #5 clk = ~clk;

  alu_iter #(.XLEN(32)) dut32 (
    .clk_i(clk), .rst_ni(rstN), .valid_i(valid32), .ready_o(ready32), .op_i(op),
    .operand1_i(a32), .operand2_i(b32), .kill_i(kill), .valid_o(vOut32),
    .ready_i(readyIn), .ALUResult_o(res32), .zero_o(zero32), .illegal_o(ill32)
  );

  alu_iter #(.XLEN(64)) dut64 (
    .clk_i(clk), .rst_ni(rstN), .valid_i(valid64), .ready_o(ready64), .op_i(op),
    .operand1_i(a64), .operand2_i(b64), .kill_i(kill), .valid_o(vOut64),
    .ready_i(readyIn), .ALUResult_o(res64), .zero_o(zero64), .illegal_o(ill64)
  );

  function automatic logic selValid(input int xl);
    return (xl == 32) ? vOut32 : vOut64;
  endfunction
  function automatic logic selReady(input int xl);
    return (xl == 32) ? ready32 : ready64;
  endfunction
  function automatic logic [63:0] selRes(input int xl);
    return (xl == 32) ? {32'b0, res32} : res64;
  endfunction
  function automatic logic selZero(input int xl);
    return (xl == 32) ? zero32 : zero64;
  endfunction
  function automatic logic selIll(input int xl);
    return (xl == 32) ? ill32 : ill64;
  endfunction

  function automatic logic [63:0] refModel(input int xl, input logic [4:0] o,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, ua, ub, sa, sb, minv, r;
    logic signed [127:0] p;
    int sh;
    bit ovf;
    mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    ua   = a & mask;
    ub   = b & mask;
    sa   = (xl == 32) ? {{32{a[31]}}, a[31:0]} : a;
    sb   = (xl == 32) ? {{32{b[31]}}, b[31:0]} : b;
    minv = (xl == 32) ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    ovf  = (sa == minv) && (sb == '1);
    sh   = int'(b[5:0]) & (xl - 1);
    r    = '0;
    case (o)
      5'd0: r = ua & ub;
      5'd1: r = ua | ub;
      5'd2: r = ua + ub;
      5'd3: r = ua - ub;
      5'd4: r = ua ^ ub;
      5'd5: r = ua << sh;
      5'd6: r = ua >> sh;
      5'd7: r = {63'b0, ua < ub};
      5'd8: r = $signed(sa) >>> sh;
      5'd9: r = {63'b0, $signed(sa) < $signed(sb)};
      5'd16, 5'd19: begin
        p = $signed({64'b0, ua}) * $signed({64'b0, ub});
        r = (o == 5'd16) ? p[63:0] : ((xl == 32) ? {32'b0, p[63:32]} : p[127:64]);
      end
      5'd17: begin
        p = $signed({{64{sa[63]}}, sa}) * $signed({{64{sb[63]}}, sb});
        r = (xl == 32) ? {32'b0, p[63:32]} : p[127:64];
      end
      5'd18: begin
        p = $signed({{64{sa[63]}}, sa}) * $signed({64'b0, ub});
        r = (xl == 32) ? {32'b0, p[63:32]} : p[127:64];
      end
      5'd20: r = (ub == 0) ? '1 : (ovf ? sa : $signed(sa) / $signed(sb));
      5'd21: r = (ub == 0) ? '1 : ua / ub;
      5'd22: r = (ub == 0) ? ua : (ovf ? 64'b0 : $signed(sa) % $signed(sb));
      5'd23: r = (ub == 0) ? ua : ua % ub;
      default: r = '0;
    endcase
    return r & mask;
  endfunction

  function automatic exp_t makeExp(input int xl, input logic [4:0] o,
                                   input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [63:0] ub, sa, sb;
    ub = (xl == 32) ? {32'b0, b[31:0]} : b;
    sa = (xl == 32) ? {{32{a[31]}}, a[31:0]} : a;
    sb = (xl == 32) ? {{32{b[31]}}, b[31:0]} : b;
    e.res  = refModel(xl, o, a, b);
    e.zero = (e.res == 0);
    e.ill  = !((o <= 5'd9) || (o >= 5'd16 && o <= 5'd23));
    e.lat  = 1;
    if (o >= 5'd16 && o <= 5'd19) e.lat = xl + 1;
    if (o >= 5'd20 && o <= 5'd23 && ub != 0 &&
        !((o == 5'd20 || o == 5'd22) && sb == '1 &&
          sa == ((xl == 32) ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)))
      e.lat = xl + 1;
    return e;
  endfunction

  // Must be entered at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic startOp(input int xl, input logic [4:0] o, input logic [63:0] a,
                         input logic [63:0] b, input bit push, input bit given,
                         input logic [63:0] want);
    exp_t e;
    if (push) begin
      e = makeExp(xl, o, a, b);
      if (given) begin
        e.res  = want;
        e.zero = (want == 0);
      end
      sbQ.push_back(e);
    end
    op = o; a32 = a[31:0]; b32 = b[31:0]; a64 = a; b64 = b;
    valid32 = (xl == 32);
    valid64 = (xl == 64);
    @(negedge clk);
    valid32 = 1'b0; valid64 = 1'b0;
    op = 5'($urandom); a32 = $urandom; b32 = $urandom;
    a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
  endtask

  task automatic collectResult(input string tag, input int xl, output exp_t e);
    int lat;
    bit busyReady;
    lat = 1;
    busyReady = 0;
    while (!selValid(xl) && lat < 200) begin
      if (selReady(xl)) busyReady = 1;
      @(negedge clk);
      lat++;
    end
    if (selReady(xl)) busyReady = 1;
    checks++;
    if (sbQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s scoreboard got empty queue want one entry", tag);
      e = '{default: 0};
      return;
    end
    e = sbQ.pop_front();
    if (lat !== e.lat) begin
      errors++;
      $display("[TB] FAIL %s latency got %0d want %0d", tag, lat, e.lat);
    end
    checks++;
    if (selRes(xl) !== e.res) begin
      errors++;
      $display("[TB] FAIL %s result got %h want %h", tag, selRes(xl), e.res);
    end
    checks++;
    if (selZero(xl) !== e.zero) begin
      errors++;
      $display("[TB] FAIL %s zero_o got %b want %b", tag, selZero(xl), e.zero);
    end
    checks++;
    if (selIll(xl) !== e.ill) begin
      errors++;
      $display("[TB] FAIL %s illegal_o got %b want %b", tag, selIll(xl), e.ill);
    end
    checks++;
    if (busyReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s ready_o while busy got 1 want 0", tag);
    end
  endtask

  task automatic retire(input string tag, input int xl);
    readyIn = 1'b1;
    @(negedge clk);
    readyIn = 1'b0;
    checks++;
    if (selValid(xl) !== 1'b0 || selReady(xl) !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s retire valid_o/ready_o got %b/%b want 0/1", tag, selValid(xl), selReady(xl));
    end
  endtask

  task automatic runOp(input string tag, input int xl, input logic [4:0] o,
                       input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    startOp(xl, o, a, b, 1, 0, '0);
    collectResult(tag, xl, e);
    retire(tag, xl);
  endtask

  task automatic runKnown(input string tag, input int xl, input logic [4:0] o,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] want);
    exp_t e;
    startOp(xl, o, a, b, 1, 1, want);
    collectResult(tag, xl, e);
    retire(tag, xl);
  endtask

  task automatic test_reset();
    rstN = 1'b0; valid32 = 0; valid64 = 0; kill = 0; readyIn = 0;
    op = '0; a32 = '0; b32 = '0; a64 = '0; b64 = '0;
    #12;
    checks++;
    if ({ready32, vOut32, res32, zero32, ill32} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset32 rdy/vld/res/zero/ill got %b/%b/%h/%b/%b want 1/0/0/1/0",
               ready32, vOut32, res32, zero32, ill32);
    end
    checks++;
    if ({ready64, vOut64, res64, zero64, ill64} !== {1'b1, 1'b0, 64'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset64 rdy/vld/res/zero/ill got %b/%b/%h/%b/%b want 1/0/0/1/0",
               ready64, vOut64, res64, zero64, ill64);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    runKnown("add_ovf", 32, ADD, 64'h7FFF_FFFF, 64'h1, 64'h8000_0000);
    runKnown("sub_zero", 32, SUB, 64'h5, 64'h5, 64'h0);
    runKnown("sra_shamt", 32, SRA, 64'h8000_0000, 64'h21, 64'hC000_0000);
    runKnown("slt", 32, SLT, 64'hFFFF_FFFF, 64'h1, 64'h1);
    runKnown("sltu", 32, SLTU, 64'hFFFF_FFFF, 64'h1, 64'h0);
    for (int i = 0; i < 12; i++)
      runOp("single_rand", 32, 5'($urandom_range(0, 9)), {32'b0, $urandom}, {32'b0, $urandom});
  endtask

  task automatic test_mul();
    runKnown("mulh_m1", 32, MULH, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0);
    runKnown("mulhu_m1", 32, MULHU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE);
    runKnown("mul_m1", 32, MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h1);
    runKnown("mulhsu_m1", 32, MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    for (int i = 0; i < 6; i++)
      runOp("mul_rand", 32, 5'($urandom_range(16, 19)), {32'b0, $urandom}, {32'b0, $urandom});
  endtask

  task automatic test_div();
    runKnown("div_neg", 32, DIV, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFD);
    runKnown("rem_neg", 32, REM, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFF);
    runKnown("divu_by0", 32, DIVU, 64'h7, 64'h0, 64'hFFFF_FFFF);
    runKnown("remu_by0", 32, REMU, 64'h7, 64'h0, 64'h7);
    runKnown("div_ovf", 32, DIV, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000);
    runKnown("rem_ovf", 32, REM, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0);
    for (int i = 0; i < 6; i++)
      runOp("div_rand", 32, 5'($urandom_range(20, 23)), {32'b0, $urandom}, {32'b0, $urandom_range(1, 5000)});
  endtask

  task automatic test_illegal();
    runKnown("illegal31", 32, 5'd31, 64'h1234, 64'h5678, 64'h0);
    runKnown("illegal12", 32, 5'd12, 64'hFFFF, 64'h1, 64'h0);
  endtask

  task automatic test_hold();
    exp_t e;
    bit stable;
    startOp(32, MULHSU, {32'b0, $urandom}, {32'b0, $urandom}, 1, 0, '0);
    collectResult("hold", 32, e);
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (vOut32 !== 1'b1 || ready32 !== 1'b0 || {32'b0, res32} !== e.res) stable = 0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold stability got vld=%b rdy=%b res=%h want 1/0/%h", vOut32, ready32, res32, e.res);
    end
    retire("hold", 32);
  endtask

  task automatic test_kill();
    bit sawValid;
    startOp(32, DIV, 64'h1234_5678, 64'h9, 0, 0, '0);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    checks++;
    if (ready32 !== 1'b1 || vOut32 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL kill_div ready/valid got %b/%b want 1/0", ready32, vOut32);
    end
    sawValid = 0;
    repeat (40) begin
      @(negedge clk);
      if (vOut32) sawValid = 1;
    end
    checks++;
    if (sawValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL kill_div late valid_o got 1 want 0");
    end
    startOp(32, ADD, 64'h3, 64'h4, 0, 0, '0);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    checks++;
    if (ready32 !== 1'b1 || vOut32 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL kill_done ready/valid got %b/%b want 1/0", ready32, vOut32);
    end
    op = ADD; a32 = 32'h1; b32 = 32'h1; valid32 = 1'b1; kill = 1'b1;
    @(negedge clk);
    valid32 = 1'b0; kill = 1'b0;
    sawValid = 0;
    repeat (3) begin
      if (vOut32 || !ready32) sawValid = 1;
      @(negedge clk);
    end
    checks++;
    if (sawValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL kill_idle accepted got 1 want 0");
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    startOp(32, ADD, 64'h1, 64'h2, 1, 0, '0);
    collectResult("b2b_first", 32, e);
    sbQ.push_back(makeExp(32, SUB, 64'h30, 64'h10));
    readyIn = 1'b1; valid32 = 1'b1; op = SUB; a32 = 32'h30; b32 = 32'h10;
    @(negedge clk);
    readyIn = 1'b0;
    checks++;
    if (vOut32 !== 1'b0 || ready32 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b same-cycle accept valid/ready got %b/%b want 0/1", vOut32, ready32);
    end
    @(negedge clk);
    valid32 = 1'b0;
    collectResult("b2b_second", 32, e);
    retire("b2b_second", 32);
  endtask

  task automatic test_async_reset();
    bit sawValid;
    runKnown("pre_reset_add", 32, ADD, 64'h3, 64'h4, 64'h7);
    startOp(32, MUL, 64'hDEAD_BEEF, 64'h1234_5678, 0, 0, '0);
    repeat (5) @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if ({ready32, vOut32, res32, zero32, ill32} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset rdy/vld/res/zero/ill got %b/%b/%h/%b/%b want 1/0/0/1/0",
               ready32, vOut32, res32, zero32, ill32);
    end
    @(negedge clk);
    rstN = 1'b1;
    sawValid = 0;
    repeat (40) begin
      @(negedge clk);
      if (vOut32) sawValid = 1;
    end
    checks++;
    if (sawValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset partial result valid_o got 1 want 0");
    end
  endtask

  task automatic test_xlen64();
    runKnown("add64", 64, ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000);
    runKnown("sub64", 64, SUB, 64'h5, 64'h5, 64'h0);
    runKnown("sra64", 64, SRA, 64'h8000_0000_0000_0000, 64'h41, 64'hC000_0000_0000_0000);
    runKnown("slt64", 64, SLT, '1, 64'h1, 64'h1);
    runKnown("sltu64", 64, SLTU, '1, 64'h1, 64'h0);
    runKnown("mulh64", 64, MULH, '1, '1, 64'h0);
    runKnown("mulhu64", 64, MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
    runKnown("mul64", 64, MUL, '1, '1, 64'h1);
    runKnown("div64", 64, DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFD);
    runKnown("rem64", 64, REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, '1);
    runKnown("divu64_by0", 64, DIVU, 64'h7, 64'h0, '1);
    runKnown("div64_ovf", 64, DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000);
    runKnown("rem64_ovf", 64, REM, 64'h8000_0000_0000_0000, '1, 64'h0);
    for (int i = 0; i < 6; i++)
      runOp("rand64", 64, 5'($urandom_range(16, 23)), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_div();
    test_illegal();
    test_hold();
    test_kill();
    test_back_to_back();
    test_async_reset();
    test_xlen64();
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard leftover entries got %0d want 0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
